// File: rtl/i2s_trnmtr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2s_trnmtr_ctrl
// Description : Timing and sample-sequencing controller for the I2S transmit
//               path. Divides clk into sck/ws, accepts stereo pairs over a
//               valid/ready handshake and drives the load/shift strobes of a
//               downstream 32-bit shift register for standard I2S framing.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_trnmtr_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        enable,
  input  logic [31:0] left_in,
  input  logic [31:0] right_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [31:0] data_out,
  output logic        load,
  output logic        shift,
  output logic        sck,
  output logic        ws,
  output logic        underrun
);

  localparam int              DW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [4:0]      SLOT_LAST = 5'd31;
  localparam logic [4:0]      SLOT_LOAD = 5'd1;

  localparam logic [1:0]      IDLE      = 2'd0;
  localparam logic [1:0]      RUN       = 2'd1;
  localparam logic [1:0]      FLUSH     = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] div_cnt;
  logic [4:0]    slot;
  logic [4:0]    slot_next;
  logic [31:0]   left_hold;
  logic [31:0]   right_hold;
  logic          fall;
  logic          run_fall;
  logic          frame_end;
  logic          capture;

  // Event decode and the combinational strobes issued in the sck-fall cycle
  always_comb begin
    fall         = (state != IDLE) && (div_cnt == DIV_LAST) && sck;
    run_fall     = fall && (state == RUN);
    slot_next    = slot + 5'd1;
    // Right-channel slot 31 wrapping back to a new left half-frame
    frame_end    = run_fall && (slot == SLOT_LAST) && ws;
    capture      = frame_end && enable;
    sample_ready = capture;
    underrun     = capture && !sample_valid;
    load         = run_fall && (slot_next == SLOT_LOAD);
    shift        = run_fall && (slot_next != SLOT_LOAD);
  end

  // Clock divider: produces sck while running, parked low in IDLE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Frame sequencer: state, bit slot and word select
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      slot  <= SLOT_LAST;
      ws    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (run_fall) begin
            slot <= slot_next;
            if (slot == SLOT_LAST) begin
              // Stopping holds ws high so FLUSH clocks out the right LSB
              if (ws && !enable) state <= FLUSH;
              else               ws    <= ~ws;
            end
          end
        end
        FLUSH: begin
          if (fall) begin
            state <= IDLE;
            slot  <= SLOT_LAST;
            ws    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sample holding registers, loaded (or zeroed on underrun) at frame start
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      left_hold  <= '0;
      right_hold <= '0;
    end else if (capture) begin
      left_hold  <= sample_valid ? left_in  : 32'd0;
      right_hold <= sample_valid ? right_in : 32'd0;
    end
  end

  // Registered channel mux feeding the shift register parallel input
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) data_out <= '0;
    else        data_out <= ws ? right_hold : left_hold;
  end

endmodule
`default_nettype wire
